// File: rtl/axi_aw_master.sv
// ---------------------------------------------------------------------------
// axi_aw_master
//
// Queues write-address commands in a small FIFO and issues them on an AXI
// write-address (AW) channel.  A two-state FSM (IDLE / SEND) owns AWVALID;
// once raised, AWVALID and the AW payload hold until the slave accepts.  A
// new head is loaded in the handshake cycle, so transfers run back to back
// when commands are waiting.  A 16-bit stall counter flags a sticky error
// if AWVALID sits unaccepted for TIMEOUT edges.
//
// Ports
//   ACLK          in   clock, rising-edge active
//   ARESETn       in   asynchronous reset, active HIGH (legacy naming)
//   cmd_valid     in   command request
//   cmd_ready     out  queue has a free slot (registered state only)
//   cmd_addr      in   [ADDR_W] command address
//   cmd_prot      in   [3] command protection bits
//   AWVALID       out  write-address valid
//   AWREADY       in   write-address ready from slave
//   AWADDR        out  [ADDR_W] write address
//   AWPROT        out  [3] write protection
//   busy          out  queue non-empty or AWVALID high
//   issued_count  out  [8] completed AW handshakes, wrapping
//   stall_err     out  sticky stall-timeout flag
// ---------------------------------------------------------------------------
module axi_aw_master #(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_prot,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic [2:0]        AWPROT,
    output logic              busy,
    output logic [7:0]        issued_count,
    output logic              stall_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [ADDR_W-1:0]  r_awaddr;
    logic [2:0]         r_awprot;
    logic [7:0]         r_issued;
    logic [15:0]        r_stall_cnt;
    logic               r_stall_err;

    logic               w_not_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_handshake;
    logic               w_stalled;
    logic [15:0]        w_stall_inc;

    // cmd_ready comes from the registered count only, so there is no
    // combinational path from AWREADY to cmd_ready.
    assign cmd_ready    = (r_count != CNT_W'(DEPTH));
    assign w_not_empty  = (r_count != {CNT_W{1'b0}});
    assign w_push       = cmd_valid && cmd_ready;
    assign w_stall_inc  = r_stall_cnt + 16'd1;

    assign AWVALID      = (r_state == ST_SEND);
    assign AWADDR       = r_awaddr;
    assign AWPROT       = r_awprot;
    assign busy         = w_not_empty || AWVALID;
    assign issued_count = r_issued;
    assign stall_err    = r_stall_err;

    // FSM state register.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: leave SEND only on a handshake with nothing queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (AWREADY && !w_not_empty) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: queue pop, handshake and stall strobes.
    always_comb begin
        w_pop       = 1'b0;
        w_handshake = 1'b0;
        w_stalled   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pop = w_not_empty;
            end
            ST_SEND: begin
                w_handshake = AWREADY;
                w_pop       = AWREADY && w_not_empty;
                w_stalled   = !AWREADY;
            end
            default: begin
                w_pop       = 1'b0;
                w_handshake = 1'b0;
                w_stalled   = 1'b0;
            end
        endcase
    end

    // Command FIFO storage and pointers; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ENT_W{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {cmd_addr, cmd_prot};
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
            end
        end
    end

    // Occupancy count: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1'b1);
                2'b01:   r_count <= r_count - CNT_W'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // AW payload register: loads only on pop, otherwise holds (incl. after drain).
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_awaddr <= {ADDR_W{1'b0}};
            r_awprot <= 3'b000;
        end else if (w_pop) begin
            {r_awaddr, r_awprot} <= r_mem[r_rd_ptr];
        end
    end

    // Completed-handshake counter, wraps 255 -> 0.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_issued <= 8'd0;
        end else if (w_handshake) begin
            r_issued <= r_issued + 8'd1;
        end
    end

    // Stall counter (saturating) and sticky timeout flag; the flag never
    // feeds back into the AW channel.
    always_ff @(posedge ACLK or posedge ARESETn) begin
        if (ARESETn) begin
            r_stall_cnt <= 16'd0;
            r_stall_err <= 1'b0;
        end else if (w_stalled) begin
            if (r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= w_stall_inc;
            end
            if (w_stall_inc == 16'(TIMEOUT)) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_stall_cnt <= 16'd0;
        end
    end

endmodule
